mem_access_stage: RTL and testbench

MEM pipeline stage that sits directly upstream of the writeback stage. Takes the EX/MEM pipeline fields and drives a req/ack data-memory interface, with a timeout on unanswered requests. Stalls the upstream pipeline while an access is outstanding. Registers the MEM/WB fields (read data, ALU result, control) that the writeback stage consumes.

---
 rtl/mem_access_stage.sv | 139 +++++++++++++
 tb/tb_mem_access_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port with timeout and registers MEM/WB fields.
// Optional build macro MEM_ALIGN_CHECK_EN rejects memory ops whose address is not word aligned.
module mem_access_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      iValid,
    input  logic                      iSig_MemRead,
    input  logic                      iSig_MemWrite,
    input  logic                      iSig_regfile_write,
    input  logic                      iSig_MemtoReg,
    input  logic [DATA_WIDTH-1:0]     ialu_result,
    input  logic [DATA_WIDTH-1:0]     iwrite_data,
    input  logic [REG_ADDR_WIDTH-1:0] iwrite_reg,
    output logic                      ostall,
    output logic                      omem_req,
    output logic                      omem_we,
    output logic [DATA_WIDTH-1:0]     omem_addr,
    output logic [DATA_WIDTH-1:0]     omem_wdata,
    input  logic                      imem_ack,
    input  logic [DATA_WIDTH-1:0]     imem_rdata,
    output logic                      oValid,
    output logic                      oSig_regfile_write,
    output logic                      oSig_MemtoReg,
    output logic [DATA_WIDTH-1:0]     oread_from_ram,
    output logic [DATA_WIDTH-1:0]     oalu_result,
    output logic [REG_ADDR_WIDTH-1:0] owrite_reg,
    output logic                      oerr
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic                      cap_regfile_write;
    logic                      cap_memtoreg;
    logic [REG_ADDR_WIDTH-1:0] cap_write_reg;
    logic                      mem_op;
    logic                      misaligned;
    logic                      timed_out;

    assign ostall    = (state == ACCESS);
    assign mem_op    = iSig_MemRead | iSig_MemWrite;
    assign timed_out = (cnt == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |ialu_result[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // The captured address doubles as the ALU result handed to writeback.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            cnt                <= '0;
            cap_regfile_write  <= 1'b0;
            cap_memtoreg       <= 1'b0;
            cap_write_reg      <= '0;
            omem_req           <= 1'b0;
            omem_we            <= 1'b0;
            omem_addr          <= '0;
            omem_wdata         <= '0;
            oValid             <= 1'b0;
            oSig_regfile_write <= 1'b0;
            oSig_MemtoReg      <= 1'b0;
            oread_from_ram     <= '0;
            oalu_result        <= '0;
            owrite_reg         <= '0;
            oerr               <= 1'b0;
        end else begin
            oerr <= 1'b0;
            case (state)
                IDLE: begin
                    if (!iValid) begin
                        oValid             <= 1'b0;
                        oSig_regfile_write <= 1'b0;
                    end else if (!mem_op) begin
                        oValid             <= 1'b1;
                        oSig_regfile_write <= iSig_regfile_write;
                        oSig_MemtoReg      <= iSig_MemtoReg;
                        oalu_result        <= ialu_result;
                        owrite_reg         <= iwrite_reg;
                    end else if (misaligned) begin
                        oValid             <= 1'b1;
                        oSig_regfile_write <= 1'b0;
                        oSig_MemtoReg      <= iSig_MemtoReg;
                        oalu_result        <= ialu_result;
                        owrite_reg         <= iwrite_reg;
                        oerr               <= 1'b1;
                    end else begin
                        state              <= ACCESS;
                        cnt                <= '0;
                        cap_regfile_write  <= iSig_regfile_write;
                        cap_memtoreg       <= iSig_MemtoReg;
                        cap_write_reg      <= iwrite_reg;
                        omem_req           <= 1'b1;
                        omem_we            <= iSig_MemWrite;
                        omem_addr          <= ialu_result;
                        omem_wdata         <= iwrite_data;
                        oValid             <= 1'b0;
                        oSig_regfile_write <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (imem_ack || timed_out) begin
                        state              <= IDLE;
                        omem_req           <= 1'b0;
                        omem_we            <= 1'b0;
                        oValid             <= 1'b1;
                        oSig_MemtoReg      <= cap_memtoreg;
                        oalu_result        <= omem_addr;
                        owrite_reg         <= cap_write_reg;
                        // Ack on the final cycle still counts as a normal completion.
                        if (imem_ack) begin
                            oSig_regfile_write <= cap_regfile_write;
                            if (!omem_we) begin
                                oread_from_ram <= imem_rdata;
                            end
                        end else begin
                            oSig_regfile_write <= 1'b0;
                            oerr               <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed plus random transactions against a transaction-level model.
module tb_mem_access_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          iValid, iSig_MemRead, iSig_MemWrite, iSig_regfile_write, iSig_MemtoReg;
    logic [DW-1:0] ialu_result, iwrite_data;
    logic [RW-1:0] iwrite_reg;
    logic          ostall, omem_req, omem_we;
    logic [DW-1:0] omem_addr, omem_wdata;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          oValid, oSig_regfile_write, oSig_MemtoReg;
    logic [DW-1:0] oread_from_ram, oalu_result;
    logic [RW-1:0] owrite_reg;
    logic          oerr;

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] exp_rd = '0;

    mem_access_stage #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .iValid(iValid), .iSig_MemRead(iSig_MemRead),
        .iSig_MemWrite(iSig_MemWrite), .iSig_regfile_write(iSig_regfile_write),
        .iSig_MemtoReg(iSig_MemtoReg), .ialu_result(ialu_result), .iwrite_data(iwrite_data),
        .iwrite_reg(iwrite_reg), .ostall(ostall), .omem_req(omem_req), .omem_we(omem_we),
        .omem_addr(omem_addr), .omem_wdata(omem_wdata), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .oValid(oValid), .oSig_regfile_write(oSig_regfile_write),
        .oSig_MemtoReg(oSig_MemtoReg), .oread_from_ram(oread_from_ram),
        .oalu_result(oalu_result), .owrite_reg(owrite_reg), .oerr(oerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        iSig_MemRead       = 1'($urandom);
        iSig_MemWrite      = 1'($urandom);
        iSig_regfile_write = 1'($urandom);
        iSig_MemtoReg      = 1'($urandom);
        ialu_result        = $urandom;
        iwrite_data        = $urandom;
        iwrite_reg         = RW'($urandom);
    endtask

    // One instruction through the stage; ack_dly > TO means the memory never answers.
    task automatic do_txn(input logic rd, input logic wr, input logic rfw, input logic m2r,
                          input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [RW-1:0] wreg, input int ack_dly, input logic [DW-1:0] rdata);
        logic memop;
        logic mis;
        logic done;
        memop = rd | wr;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (addr % 4) != 0;
`else
        mis = 1'b0;
`endif
        @(negedge clk);
        iValid = 1'b1; iSig_MemRead = rd; iSig_MemWrite = wr;
        iSig_regfile_write = rfw; iSig_MemtoReg = m2r;
        ialu_result = addr; iwrite_data = wdata; iwrite_reg = wreg;
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        @(posedge clk); #1;
        if (!memop) begin
            chk("pass_valid", oValid, 1'b1);
            chk("pass_rfw", oSig_regfile_write, rfw);
            chk("pass_m2r", oSig_MemtoReg, m2r);
            chk("pass_alu", oalu_result, addr);
            chk("pass_wreg", owrite_reg, wreg);
            chk("pass_rd_hold", oread_from_ram, exp_rd);
            chk("pass_stall", ostall, 1'b0);
            chk("pass_req", omem_req, 1'b0);
            chk("pass_err", oerr, 1'b0);
        end else if (mis) begin
            chk("mis_req", omem_req, 1'b0);
            chk("mis_stall", ostall, 1'b0);
            chk("mis_valid", oValid, 1'b1);
            chk("mis_rfw", oSig_regfile_write, 1'b0);
            chk("mis_err", oerr, 1'b1);
            chk("mis_rd_hold", oread_from_ram, exp_rd);
        end else begin
            chk("cap_req", omem_req, 1'b1);
            chk("cap_stall", ostall, 1'b1);
            chk("cap_we", omem_we, wr);
            chk("cap_addr", omem_addr, addr);
            chk("cap_wdata", omem_wdata, wdata);
            chk("cap_bubble", oValid, 1'b0);
            done = 1'b0;
            for (int k = 1; k <= TO && !done; k++) begin
                @(negedge clk);
                iValid = 1'($urandom);
                scramble_inputs();
                imem_ack   = (k == ack_dly);
                imem_rdata = (k == ack_dly) ? rdata : $urandom;
                @(posedge clk); #1;
                if (k == ack_dly) begin
                    done = 1'b1;
                    if (!wr) exp_rd = rdata;
                    chk("cpl_req", omem_req, 1'b0);
                    chk("cpl_stall", ostall, 1'b0);
                    chk("cpl_valid", oValid, 1'b1);
                    chk("cpl_err", oerr, 1'b0);
                    chk("cpl_rfw", oSig_regfile_write, rfw);
                    chk("cpl_m2r", oSig_MemtoReg, m2r);
                    chk("cpl_alu", oalu_result, addr);
                    chk("cpl_wreg", owrite_reg, wreg);
                    chk("cpl_rd", oread_from_ram, exp_rd);
                end else if (k == TO) begin
                    done = 1'b1;
                    chk("to_req", omem_req, 1'b0);
                    chk("to_stall", ostall, 1'b0);
                    chk("to_valid", oValid, 1'b1);
                    chk("to_rfw", oSig_regfile_write, 1'b0);
                    chk("to_err", oerr, 1'b1);
                    chk("to_rd_hold", oread_from_ram, exp_rd);
                end else begin
                    chk("acc_req", omem_req, 1'b1);
                    chk("acc_stall", ostall, 1'b1);
                    chk("acc_we", omem_we, wr);
                    chk("acc_addr", omem_addr, addr);
                    chk("acc_wdata", omem_wdata, wdata);
                    chk("acc_valid", oValid, 1'b0);
                end
            end
        end
        // Idle cycle with a stray ack that must be ignored.
        @(negedge clk);
        iValid = 1'b0; scramble_inputs();
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        @(posedge clk); #1;
        chk("idle_valid", oValid, 1'b0);
        chk("idle_rfw", oSig_regfile_write, 1'b0);
        chk("idle_err", oerr, 1'b0);
        chk("idle_req", omem_req, 1'b0);
        chk("idle_stall", ostall, 1'b0);
        chk("idle_rd_hold", oread_from_ram, exp_rd);
        imem_ack = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; iValid = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        scramble_inputs();
        #2;
        chk("rst_valid", oValid, 1'b0);
        chk("rst_req", omem_req, 1'b0);
        chk("rst_stall", ostall, 1'b0);
        chk("rst_err", oerr, 1'b0);
        chk("rst_rd", oread_from_ram, '0);
        chk("rst_alu", oalu_result, '0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        do_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 0, 32'h0);
        do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd3, 3, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 1, 32'h1111_2222);
        do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd9, TO + 1, 32'h0);
        do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 32'h0, 5'd10, TO, 32'h600D_F00D);
        do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd11, 2, 32'h0BAD_0102);
        do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h5555_AAAA, 5'd12, 2, 32'h7777_7777);

        for (int i = 0; i < 60; i++) begin
            do_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   ((i % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                   $urandom, RW'($urandom), int'($urandom_range(1, TO + 1)), $urandom);
        end

        // Reset in the middle of an unanswered access.
        @(negedge clk);
        iValid = 1'b1; iSig_MemRead = 1'b1; iSig_MemWrite = 1'b0;
        iSig_regfile_write = 1'b1; ialu_result = 32'h0000_0800; imem_ack = 1'b0;
        @(posedge clk); #1;
        chk("mid_req_up", omem_req, 1'b1);
        @(negedge clk);
        iValid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_req_drop", omem_req, 1'b0);
        chk("mid_stall", ostall, 1'b0);
        chk("mid_valid", oValid, 1'b0);
        exp_rd = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", oValid, 1'b0);
        chk("post_rst_req", omem_req, 1'b0);
        chk("post_rst_stall", ostall, 1'b0);
        chk("post_rst_rd", oread_from_ram, exp_rd);
        do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0900, 32'h0, 5'd4, 2, 32'hCAFE_0900);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
